// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one RAM port among NUM_PORTS requesters on a single clock.
// PRIO_PORT (normally VGA scanout) has strict priority, limited to
// MAX_PRIO_RUN consecutive grants while another port waits. The other
// ports are served round-robin. Each read returns a one-cycle rvalid
// strobe to its requester once the RAM read latency has elapsed.
//
// Ports:
//   clock        in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   req          in   per-port request, held until granted
//   wren         in   per-port write enable, qualified by req
//   address      in   per-port address, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   data         in   per-port write data, same packing
//   gnt          out  one-hot combinational grant
//   rvalid       out  one-cycle read-return strobe per port
//   rdata        out  read data, broadcast (pass-through of mem_q)
//   mem_address  out  registered RAM address
//   mem_wren     out  registered RAM write enable
//   mem_data     out  registered RAM write data
//   mem_q        in   RAM read data
//
// Handshake: a port raises req[k] and holds it, together with its
// wren/address/data, until it sees gnt[k]. The access is accepted at the
// rising edge where req[k] & gnt[k] is high. Every edge with both high is a
// separate access, so the requester must drop req or present its next
// command in the cycle after acceptance. rvalid carries no back-pressure.
module ram_arbiter #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int PRIO_PORT    = 0,
    parameter int MAX_PRIO_RUN = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             wren,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  data,
    output logic [NUM_PORTS-1:0]             gnt,
    output logic [NUM_PORTS-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic                             mem_wren,
    output logic [DATA_WIDTH-1:0]            mem_data,
    input  logic [DATA_WIDTH-1:0]            mem_q
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    // One stage for the registered command, READ_LATENCY stages for the RAM.
    localparam int DEPTH = 1 + READ_LATENCY;
    localparam logic [NUM_PORTS-1:0] PRIO_MASK = NUM_PORTS'(1) << PRIO_PORT;
    localparam logic [3:0] MAX_RUN = 4'(MAX_PRIO_RUN);

    logic [IDX_W-1:0]      r_rr_ptr;
    logic [3:0]            r_prio_run;
    logic [DEPTH-1:0]      r_tag_v;
    logic [IDX_W-1:0]      r_tag_idx [DEPTH];

    logic                  w_other_req;
    logic                  w_gnt_valid;
    logic                  w_prio_grant;
    logic                  w_found;
    logic [IDX_W-1:0]      w_gnt_idx;
    logic [NUM_PORTS-1:0]  w_gnt;
    int                    w_cand;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_wren;
    logic                  w_rd_accept;

    assign w_other_req = |(req & ~PRIO_MASK);

    // Grant selection. The priority port wins unless it has used up its run
    // while someone else waits; otherwise the round-robin search starts just
    // above the last non-priority winner and wraps, skipping PRIO_PORT.
    always_comb begin
        w_gnt        = '0;
        w_gnt_idx    = '0;
        w_gnt_valid  = 1'b0;
        w_prio_grant = 1'b0;
        w_found      = 1'b0;
        w_cand       = 0;
        if (reset_n) begin
            if (req[PRIO_PORT] && ((r_prio_run < MAX_RUN) || !w_other_req)) begin
                w_prio_grant = 1'b1;
                w_gnt_valid  = 1'b1;
                w_gnt_idx    = IDX_W'(PRIO_PORT);
            end else if (w_other_req) begin
                for (int i = 1; i <= NUM_PORTS; i++) begin
                    w_cand = int'(r_rr_ptr) + i;
                    if (w_cand >= NUM_PORTS) begin
                        w_cand = w_cand - NUM_PORTS;
                    end
                    if (!w_found && (w_cand != PRIO_PORT) && req[IDX_W'(w_cand)]) begin
                        w_found   = 1'b1;
                        w_gnt_idx = IDX_W'(w_cand);
                    end
                end
                w_gnt_valid = w_found;
            end
            if (w_gnt_valid) begin
                w_gnt[w_gnt_idx] = 1'b1;
            end
        end
    end

    assign gnt = w_gnt;

    // Command mux driven by the one-hot grant.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_wren = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_gnt[k]) begin
                w_sel_addr = address[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = data[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_wren = wren[k];
            end
        end
    end

    // gnt already implies req, so a grant is an accepted access.
    assign w_rd_accept = w_gnt_valid && !w_sel_wren;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr    <= IDX_W'(PRIO_PORT);
            r_prio_run  <= '0;
            r_tag_v     <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                r_tag_idx[s] <= '0;
            end
            mem_address <= '0;
            mem_wren    <= 1'b0;
            mem_data    <= '0;
        end else begin
            // Run length only matters while someone else is waiting.
            if (!w_other_req) begin
                r_prio_run <= '0;
            end else if (w_prio_grant) begin
                if (r_prio_run < MAX_RUN) begin
                    r_prio_run <= r_prio_run + 4'd1;
                end
            end else begin
                r_prio_run <= '0;
            end

            if (w_gnt_valid && !w_prio_grant) begin
                r_rr_ptr <= w_gnt_idx;
            end

            // Address/data hold across idle cycles; only wren is cleared.
            if (w_gnt_valid) begin
                mem_address <= w_sel_addr;
                mem_wren    <= w_sel_wren;
                mem_data    <= w_sel_data;
            end else begin
                mem_wren    <= 1'b0;
            end

            r_tag_v      <= {r_tag_v[DEPTH-2:0], w_rd_accept};
            r_tag_idx[0] <= w_gnt_idx;
            for (int s = 1; s < DEPTH; s++) begin
                r_tag_idx[s] <= r_tag_idx[s-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (r_tag_v[DEPTH-1]) begin
            rvalid[r_tag_idx[DEPTH-1]] = 1'b1;
        end
    end

    assign rdata = mem_q;

endmodule
